mem_line_adapter: RTL and testbench

//  Sits between the cache memory port and the word-wide (BIT_W) data memory.

---
 rtl/mem_line_adapter.sv | 125 ++++++++++++
 tb/tb_mem_line_adapter.sv | 230 +++++++++++++++++++++++
 2 files changed

// File: rtl/mem_line_adapter.sv
// Line-to-word adapter between the cache memory port and a word-wide data memory.
// Each line request becomes WORDS sequential single-word beats; read beats assemble the fill line.
module mem_line_adapter #(
  parameter int unsigned BIT_W  = 32,
  parameter int unsigned ADDR_W = 32,
  parameter int unsigned WORDS  = 4
) (
  input  logic                   i_clk,
  input  logic                   i_rst_n,
  input  logic                   i_cache_cen,
  input  logic                   i_cache_wen,
  input  logic [ADDR_W-1:0]      i_cache_addr,
  input  logic [BIT_W*WORDS-1:0] i_cache_wdata,
  output logic [BIT_W*WORDS-1:0] o_cache_rdata,
  output logic                   o_cache_stall,
  output logic                   o_mem_cen,
  output logic                   o_mem_wen,
  output logic [ADDR_W-1:0]      o_mem_addr,
  output logic [BIT_W-1:0]       o_mem_wdata,
  input  logic [BIT_W-1:0]       i_mem_rdata,
  input  logic                   i_mem_stall
);

  localparam int unsigned LineW = BIT_W * WORDS;
  localparam int unsigned CntW  = (WORDS > 1) ? $clog2(WORDS) : 1;

  typedef enum logic [1:0] {
    StIdle,
    StIssue,
    StWait,
    StDone
  } state_e;

  state_e             state_q, state_d;
  logic [CntW-1:0]    cnt_q, cnt_d;
  logic               wen_q, wen_d;
  logic [ADDR_W-1:0]  addr_q, addr_d;
  logic [LineW-1:0]   wdata_q, wdata_d;
  logic [LineW-1:0]   line_q, line_d;

  logic               issue;
  logic               last_beat;

  assign issue     = (state_q == StIssue);
  assign last_beat = (cnt_q == CntW'(WORDS - 1));

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    wen_d   = wen_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    line_d  = line_q;
    unique case (state_q)
      StIdle: begin
        // Request fields are captured once here; later input changes are ignored.
        if (i_cache_cen) begin
          wen_d   = i_cache_wen;
          addr_d  = i_cache_addr;
          wdata_d = i_cache_wdata;
          cnt_d   = '0;
          state_d = StIssue;
        end
      end
      StIssue: begin
        state_d = StWait;
      end
      StWait: begin
        if (!i_mem_stall) begin
          if (!wen_q) begin
            line_d[cnt_q*BIT_W +: BIT_W] = i_mem_rdata;
          end
          if (last_beat) begin
            state_d = StDone;
          end else begin
            cnt_d   = cnt_q + 1'b1;
            state_d = StIssue;
          end
        end
      end
      StDone: begin
        state_d = StIdle;
      end
      default: begin
        state_d = StIdle;
      end
    endcase
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q <= StIdle;
      cnt_q   <= '0;
      wen_q   <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      line_q  <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      wen_q   <= wen_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      line_q  <= line_d;
    end
  end

  // Stall rises combinationally on acceptance so the cache never sees a zero-cycle completion.
  always_comb begin
    o_cache_stall = ((state_q == StIdle) && i_cache_cen) ||
                    (state_q == StIssue) || (state_q == StWait);
    o_cache_rdata = line_q;
    o_mem_cen     = issue;
    o_mem_wen     = issue && wen_q;
    o_mem_addr    = '0;
    o_mem_wdata   = '0;
    if (issue) begin
      o_mem_addr = addr_q + (ADDR_W'(cnt_q) << 2);
      if (wen_q) begin
        o_mem_wdata = wdata_q[cnt_q*BIT_W +: BIT_W];
      end
    end
  end

endmodule

// File: tb/tb_mem_line_adapter.sv
// Randomised self-checking bench for mem_line_adapter against a line-level
// memory model with per-beat stall injection.
module tb_mem_line_adapter;

  localparam int unsigned BIT_W  = 32;
  localparam int unsigned ADDR_W = 32;
  localparam int unsigned WORDS  = 4;

  logic                   clk;
  logic                   rst_n;
  logic                   cache_cen;
  logic                   cache_wen;
  logic [ADDR_W-1:0]      cache_addr;
  logic [BIT_W*WORDS-1:0] cache_wdata;
  logic [BIT_W*WORDS-1:0] cache_rdata;
  logic                   cache_stall;
  logic                   mem_cen;
  logic                   mem_wen;
  logic [ADDR_W-1:0]      mem_addr;
  logic [BIT_W-1:0]       mem_wdata;
  logic [BIT_W-1:0]       mem_rdata;
  logic                   mem_stall;

  int unsigned n_checks;
  int unsigned n_fail;

  logic [31:0]  mem [logic [31:0]];
  logic [127:0] line_exp;

  mem_line_adapter #(
    .BIT_W (BIT_W),
    .ADDR_W(ADDR_W),
    .WORDS (WORDS)
  ) u_dut (
    .i_clk        (clk),
    .i_rst_n      (rst_n),
    .i_cache_cen  (cache_cen),
    .i_cache_wen  (cache_wen),
    .i_cache_addr (cache_addr),
    .i_cache_wdata(cache_wdata),
    .o_cache_rdata(cache_rdata),
    .o_cache_stall(cache_stall),
    .o_mem_cen    (mem_cen),
    .o_mem_wen    (mem_wen),
    .o_mem_addr   (mem_addr),
    .o_mem_wdata  (mem_wdata),
    .i_mem_rdata  (mem_rdata),
    .i_mem_stall  (mem_stall)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  function automatic logic [31:0] mem_rd(input logic [31:0] a);
    if (!mem.exists(a)) mem[a] = $urandom;
    return mem[a];
  endfunction

  // One line request; stl holds per-beat stall cycle counts (4 bits each).
  task automatic do_req(input logic wen, input logic [31:0] addr, input logic [127:0] wd,
                        input logic [15:0] stl, input logic keep_cen);
    logic [127:0] line_new;
    logic [31:0]  ea;
    logic [31:0]  cur_word;
    int           total;
    int           cyc;
    int           beat;
    int           rem;
    bit           pending;
    line_new = line_exp;
    total    = 2 * WORDS + 1;
    for (int k = 0; k < WORDS; k++) begin
      total += int'(stl[k*4 +: 4]);
      if (!wen) line_new[k*32 +: 32] = mem_rd(addr + 32'(4 * k));
    end
    cache_cen   = 1'b1;
    cache_wen   = wen;
    cache_addr  = addr;
    cache_wdata = wd;
    #1;
    check_eq("accept_stall", 128'(cache_stall), 128'(1));
    cyc      = 0;
    beat     = 0;
    rem      = 0;
    pending  = 0;
    cur_word = '0;
    while (cyc < 200) begin
      @(posedge clk);
      #1;
      cyc++;
      if (!cache_stall) break;
      cache_addr  = $urandom;
      cache_wdata = {$urandom, $urandom, $urandom, $urandom};
      cache_cen   = 1'($urandom % 2);
      cache_wen   = 1'($urandom % 2);
      if (mem_cen) begin
        if (beat >= WORDS || pending) begin
          check_eq("extra_beat", 128'(beat), 128'(WORDS - 1));
        end else begin
          ea = addr + 32'(4 * beat);
          check_eq("beat_addr", 128'(mem_addr), 128'(ea));
          check_eq("beat_wen", 128'(mem_wen), 128'(wen));
          check_eq("beat_wdata", 128'(mem_wdata), wen ? 128'(wd[beat*32 +: 32]) : 128'(0));
          cur_word = wen ? $urandom : mem_rd(ea);
          rem      = int'(stl[beat*4 +: 4]);
        end
        pending   = 1;
        beat++;
        mem_stall = 1'($urandom % 2);
        mem_rdata = $urandom;
      end else begin
        check_eq("wait_mem_idle", {mem_wen, mem_addr, mem_wdata}, 128'(0));
        if (pending) begin
          mem_stall = (rem > 0);
          mem_rdata = (rem > 0) ? $urandom : cur_word;
          if (rem == 0) pending = 0;
          else rem--;
        end else begin
          mem_stall = 1'b0;
          mem_rdata = $urandom;
        end
      end
    end
    check_eq("latency", 128'(cyc), 128'(total));
    check_eq("beat_count", 128'(beat), 128'(WORDS));
    check_eq("done_mem_idle", {mem_cen, mem_wen, mem_addr, mem_wdata}, 128'(0));
    line_exp = line_new;
    check_eq("line_rdata", cache_rdata, line_exp);
    if (wen) begin
      for (int k = 0; k < WORDS; k++) mem[addr + 32'(4 * k)] = wd[k*32 +: 32];
    end
    cache_cen = keep_cen;
    mem_stall = 1'b0;
    @(posedge clk);
    #1;
    check_eq("idle_stall", 128'(cache_stall), 128'(keep_cen));
    check_eq("idle_mem_cen", 128'(mem_cen), 128'(0));
  endtask

  initial begin
    logic [127:0] wd;
    logic [15:0]  stl;
    logic [31:0]  a;
    n_checks    = 0;
    n_fail      = 0;
    line_exp    = '0;
    rst_n       = 1'b0;
    cache_cen   = 1'b0;
    cache_wen   = 1'b0;
    cache_addr  = '0;
    cache_wdata = '0;
    mem_rdata   = '0;
    mem_stall   = 1'b0;
    #1;
    check_eq("reset_rdata", cache_rdata, 128'(0));
    check_eq("reset_mem", {mem_cen, mem_wen, mem_addr, mem_wdata}, 128'(0));
    check_eq("reset_stall", 128'(cache_stall), 128'(0));
    #20;
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    // Plain read with stall-free memory
    for (int k = 0; k < WORDS; k++) mem[32'h0001_0010 + 32'(4 * k)] = $urandom;
    do_req(1'b0, 32'h0001_0010, '0, 16'h0000, 1'b0);

    // Line write, then read it back with a 3-cycle stall on beat 2
    wd = {$urandom, $urandom, $urandom, $urandom};
    do_req(1'b1, 32'h0000_0100, wd, 16'h0000, 1'b0);
    do_req(1'b0, 32'h0000_0100, '0, 16'h0300, 1'b0);

    // Writeback followed by allocate with cen held across DONE
    wd = {$urandom, $urandom, $urandom, $urandom};
    do_req(1'b1, 32'h0000_0200, wd, 16'h0000, 1'b1);
    do_req(1'b0, 32'h0000_0300, '0, 16'h1021, 1'b1);
    do_req(1'b0, 32'h0000_0200, '0, 16'h0000, 1'b0);

    // Address wrap at the top of the address space
    do_req(1'b0, 32'hFFFF_FFF8, '0, 16'h0102, 1'b0);

    // Reset while beat 1 is being issued
    cache_cen  = 1'b1;
    cache_wen  = 1'b0;
    cache_addr = 32'h0000_0500;
    @(posedge clk);
    #1;
    check_eq("rst_beat0", 128'(mem_cen), 128'(1));
    mem_stall = 1'b0;
    mem_rdata = $urandom;
    @(posedge clk);
    #1;
    @(posedge clk);
    #1;
    check_eq("rst_beat1", {mem_cen, mem_addr}, {1'b1, 32'h0000_0504});
    cache_cen = 1'b0;
    rst_n     = 1'b0;
    #1;
    line_exp = '0;
    check_eq("rst_mid_rdata", cache_rdata, line_exp);
    check_eq("rst_mid_mem", {mem_cen, mem_wen, mem_addr, mem_wdata}, 128'(0));
    check_eq("rst_mid_stall", 128'(cache_stall), 128'(0));
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    check_eq("rst_no_beat", 128'(mem_cen), 128'(0));
    do_req(1'b0, 32'h0000_0500, '0, 16'h0010, 1'b0);

    // Randomised traffic over a small region so writes are read back
    for (int n = 0; n < 24; n++) begin
      a = 32'h0000_0400 + (32'($urandom_range(0, 7)) << 4);
      wd = {$urandom, $urandom, $urandom, $urandom};
      for (int k = 0; k < WORDS; k++) stl[k*4 +: 4] = 4'($urandom_range(0, 3));
      do_req(1'($urandom % 2), a, wd, stl, (n == 23) ? 1'b0 : 1'($urandom % 2));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
